// File: rtl/cgra_pkg.sv
// Shared CGRA definitions: PE config frame width and the context-sequencer state encoding.
package cgra_pkg;

  localparam int CGRA_FRAME_WIDTH = 64;

  typedef enum logic [1:0] {
    SEQ_IDLE,
    SEQ_FETCH,
    SEQ_ISSUE,
    SEQ_DONE
  } seq_state_t;

endpackage

// File: rtl/cgra_ctx_mem.sv
// Context store: 1W/1R, one-cycle synchronous read, read data holds while rd_en_i is low.
// No reset on the array or the read register; the sequencer gates the output until the first fetch.
module cgra_ctx_mem #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  input  logic [AW-1:0]    rd_addr_i,
  output logic [WIDTH-1:0] rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
    if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/cgra_pe_cfg_sequencer.sv
// Replays a window [base..last] of the context store onto a PE for N iterations, one frame/cycle.
// First frame valid 2 cycles after start; stall holds the current frame, abort returns to IDLE.
import cgra_pkg::*;

module cgra_pe_cfg_sequencer #(
  parameter int FRAME_WIDTH = CGRA_FRAME_WIDTH,
  parameter int CTX_DEPTH   = 16,
  parameter int CTX_AW      = $clog2(CTX_DEPTH),
  parameter int CNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ctx_wr_en,
  input  logic [CTX_AW-1:0]      ctx_wr_addr,
  input  logic [FRAME_WIDTH-1:0] ctx_wr_data,
  input  logic                   start,
  input  logic                   abort,
  input  logic [CTX_AW-1:0]      base_addr,
  input  logic [CTX_AW-1:0]      last_addr,
  input  logic [CNT_WIDTH-1:0]   iter_count,
  input  logic                   stall,
  output logic [FRAME_WIDTH-1:0] config_frame,
  output logic                   config_valid,
  output logic                   busy,
  output logic                   done,
  output logic [CTX_AW-1:0]      ctx_idx,
  output logic [CNT_WIDTH-1:0]   iter_idx
);

  seq_state_t             state_q, state_d;
  logic [CTX_AW-1:0]      pc_q, pc_d;
  logic [CTX_AW-1:0]      base_q, base_d;
  logic [CTX_AW-1:0]      last_q, last_d;
  logic [CNT_WIDTH-1:0]   iter_q, iter_d;
  logic [CNT_WIDTH-1:0]   tgt_q, tgt_d;
  logic                   frame_vld_q, frame_vld_d;
  logic                   rd_en;
  logic [CTX_AW-1:0]      rd_addr;
  logic [FRAME_WIDTH-1:0] rd_data;
  logic [CTX_AW-1:0]      pc_inc;

  assign pc_inc = CTX_AW'(pc_q + 1'b1);

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    base_d      = base_q;
    last_d      = last_q;
    iter_d      = iter_q;
    tgt_d       = tgt_q;
    frame_vld_d = frame_vld_q;
    rd_en       = 1'b0;
    rd_addr     = pc_q;
    case (state_q)
      SEQ_IDLE: begin
        if (start) begin
          base_d  = base_addr;
          last_d  = last_addr;
          tgt_d   = (iter_count == '0) ? CNT_WIDTH'(1) : iter_count;
          pc_d    = base_addr;
          iter_d  = '0;
          state_d = SEQ_FETCH;
        end
      end
      SEQ_FETCH: begin
        rd_en       = 1'b1;
        rd_addr     = pc_q;
        frame_vld_d = 1'b1;
        state_d     = SEQ_ISSUE;
      end
      SEQ_ISSUE: begin
        // The store is addressed with next_pc so the following frame lands with no bubble.
        if (!stall) begin
          if (pc_q != last_q) begin
            pc_d    = pc_inc;
            rd_en   = 1'b1;
            rd_addr = pc_inc;
          end else if (iter_q < tgt_q - 1'b1) begin
            iter_d  = iter_q + 1'b1;
            pc_d    = base_q;
            rd_en   = 1'b1;
            rd_addr = base_q;
          end else begin
            state_d = SEQ_DONE;
          end
        end
      end
      SEQ_DONE: state_d = SEQ_IDLE;
      default:  state_d = SEQ_IDLE;
    endcase
    if (abort && state_q != SEQ_IDLE) begin
      state_d = SEQ_IDLE;
      pc_d    = pc_q;
      iter_d  = iter_q;
      rd_en   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SEQ_IDLE;
      pc_q        <= '0;
      base_q      <= '0;
      last_q      <= '0;
      iter_q      <= '0;
      tgt_q       <= '0;
      frame_vld_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      base_q      <= base_d;
      last_q      <= last_d;
      iter_q      <= iter_d;
      tgt_q       <= tgt_d;
      frame_vld_q <= frame_vld_d;
    end
  end

  cgra_ctx_mem #(
    .DEPTH (CTX_DEPTH),
    .WIDTH (FRAME_WIDTH),
    .AW    (CTX_AW)
  ) u_ctx_mem (
    .clk       (clk),
    .wr_en_i   (ctx_wr_en && (state_q == SEQ_IDLE)),
    .wr_addr_i (ctx_wr_addr),
    .wr_data_i (ctx_wr_data),
    .rd_en_i   (rd_en),
    .rd_addr_i (rd_addr),
    .rd_data_o (rd_data)
  );

  // Read register has no reset, so mask it until a fetch has filled it.
  assign config_frame = frame_vld_q ? rd_data : '0;
  assign config_valid = (state_q == SEQ_ISSUE) && !stall;
  assign busy         = (state_q != SEQ_IDLE);
  assign done         = (state_q == SEQ_DONE);
  assign ctx_idx      = pc_q;
  assign iter_idx     = iter_q;

endmodule

// File: tb/tb_cgra_pe_cfg_sequencer.sv
// Scoreboard bench for cgra_pe_cfg_sequencer: stimulus queues expected frames/done, a monitor pops them.
module tb_cgra_pe_cfg_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ctx_wr_en = 1'b0;
  logic [3:0]  ctx_wr_addr = '0;
  logic [63:0] ctx_wr_data = '0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [3:0]  base_addr = '0;
  logic [3:0]  last_addr = '0;
  logic [15:0] iter_count = '0;
  logic        stall = 1'b0;
  logic [63:0] config_frame;
  logic        config_valid;
  logic        busy;
  logic        done;
  logic [3:0]  ctx_idx;
  logic [15:0] iter_idx;

  cgra_pe_cfg_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ctx_wr_en    (ctx_wr_en),
    .ctx_wr_addr  (ctx_wr_addr),
    .ctx_wr_data  (ctx_wr_data),
    .start        (start),
    .abort        (abort),
    .base_addr    (base_addr),
    .last_addr    (last_addr),
    .iter_count   (iter_count),
    .stall        (stall),
    .config_frame (config_frame),
    .config_valid (config_valid),
    .busy         (busy),
    .done         (done),
    .ctx_idx      (ctx_idx),
    .iter_idx     (iter_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_done;
    logic [63:0] frame;
    logic [3:0]  ctx;
    logic [15:0] iter;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] model_mem [16];
  int          passed = 0;
  int          total = 0;
  int          cyc = 0;
  int          last_vld_cyc = -10;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic fail_note(input string name);
    total++;
    $display("FAIL %s: unexpected output event at cycle %0d", name, cyc);
  endtask

  function automatic logic [63:0] pat(input int slot);
    return 64'hF00D_0000_0000_0000 | 64'(slot + 1);
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: every presented frame and every done pulse must match the head of the scoreboard.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (rst_n) begin
      if (config_valid) begin
        last_vld_cyc = cyc;
        if (sb.size() == 0) fail_note("unexpected_frame");
        else begin
          e = sb.pop_front();
          check("frame_not_done", 64'(e.is_done), 64'd0);
          check("frame", config_frame, e.frame);
          check("ctx_idx", 64'(ctx_idx), 64'(e.ctx));
          check("iter_idx", 64'(iter_idx), 64'(e.iter));
        end
      end
      if (done) begin
        if (sb.size() == 0) fail_note("unexpected_done");
        else begin
          e = sb.pop_front();
          check("done_expected", 64'(e.is_done), 64'd1);
          check("done_latency", 64'(cyc), 64'(last_vld_cyc + 1));
        end
      end
    end
  end

  task automatic write_slot(input int slot, input logic [63:0] d);
    @(posedge clk); #1;
    ctx_wr_en = 1'b1; ctx_wr_addr = 4'(slot); ctx_wr_data = d;
    model_mem[slot] = d;
    @(posedge clk); #1;
    ctx_wr_en = 1'b0;
  endtask

  task automatic push_run(input int b, input int l, input int iters, input bit with_done);
    int tgt;
    int len;
    exp_t e;
    tgt = (iters == 0) ? 1 : iters;
    len = ((l - b + 16) % 16) + 1;
    for (int it = 0; it < tgt; it++)
      for (int k = 0; k < len; k++) begin
        e.is_done = 1'b0;
        e.ctx     = 4'((b + k) % 16);
        e.frame   = model_mem[(b + k) % 16];
        e.iter    = 16'(it);
        sb.push_back(e);
      end
    if (with_done) begin
      e.is_done = 1'b1; e.frame = '0; e.ctx = '0; e.iter = '0;
      sb.push_back(e);
    end
  endtask

  // Leaves the bench at 1 ns after the edge that moved the DUT into FETCH.
  task automatic pulse_start(input int b, input int l, input int iters);
    @(posedge clk); #1;
    base_addr = 4'(b); last_addr = 4'(l); iter_count = 16'(iters); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy) fail_note({name, "_timeout"});
    @(negedge clk);
    check({name, "_sb_empty"}, 64'(sb.size()), 64'd0);
  endtask

  task automatic run(input string name, input int b, input int l, input int iters);
    push_run(b, l, iters, 1'b1);
    pulse_start(b, l, iters);
    wait_idle(name);
  endtask

  initial begin
    #23;
    check("rst_frame", config_frame, 64'd0);
    check("rst_valid", 64'(config_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_ctx_idx", 64'(ctx_idx), 64'd0);
    check("rst_iter_idx", 64'(iter_idx), 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) write_slot(i, pat(i));

    run("t1_basic", 0, 3, 1);
    check("t1_busy_low", 64'(busy), 64'd0);

    // Window of 2 for 3 passes; a mid-run start and store write must both be ignored.
    push_run(2, 3, 3, 1'b1);
    pulse_start(2, 3, 3);
    start = 1'b1; base_addr = 4'd9; last_addr = 4'd9;
    ctx_wr_en = 1'b1; ctx_wr_addr = 4'd3; ctx_wr_data = 64'hDEAD_BEEF_DEAD_BEEF;
    @(posedge clk); #1;
    start = 1'b0; ctx_wr_en = 1'b0;
    wait_idle("t2_iter");

    run("t3_wrap", 14, 1, 1);
    run("t5_iter0", 0, 1, 0);
    run("t_single", 7, 7, 2);

    // Stall three cycles on the second frame.
    push_run(0, 3, 1, 1'b1);
    pulse_start(0, 3, 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    stall = 1'b1;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      check("t4_stall_valid", 64'(config_valid), 64'd0);
      check("t4_stall_frame", config_frame, pat(1));
      @(posedge clk); #1;
    end
    stall = 1'b0;
    wait_idle("t4_stall");

    // Abort while the third frame is presented; no done pulse may follow.
    push_run(0, 2, 1, 1'b0);
    pulse_start(0, 3, 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("t5_abort_idle", 64'(busy), 64'd0);
    repeat (4) @(posedge clk);
    wait_idle("t5_abort");

    // A store write in the same IDLE cycle as start must reach the fetch.
    @(posedge clk); #1;
    ctx_wr_en = 1'b1; ctx_wr_addr = 4'd5; ctx_wr_data = 64'h0123_4567_89AB_CDEF;
    model_mem[5] = 64'h0123_4567_89AB_CDEF;
    push_run(5, 5, 1, 1'b1);
    base_addr = 4'd5; last_addr = 4'd5; iter_count = 16'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; ctx_wr_en = 1'b0;
    wait_idle("t_wr_start");

    // Reset while the second frame is on the pins.
    push_run(0, 1, 1, 1'b0);
    pulse_start(0, 3, 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", 64'(config_valid), 64'd0);
    check("t6_rst_busy", 64'(busy), 64'd0);
    check("t6_rst_frame", config_frame, 64'd0);
    check("t6_sb_drained", 64'(sb.size()), 64'd0);
    sb.delete();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    run("t6_rerun", 0, 3, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
